// File: rtl/path_planner.sv
// path_planner: breadth-first shortest-path search on the fixed 30-node arena
// graph, streaming the resulting node path (start first, end last) to the
// downstream path-mapping stage.
//
// Ports:
//   clk_3125KHz   system clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   plan_start    one-cycle request; samples start_node / end_node in IDLE
//   start_node    source node id
//   end_node      destination node id
//   busy          high while a request is being processed
//   path_input    path stream valid strobe
//   path_planned  path node id, meaningful while path_input=1
//   path_len      number of nodes in the emitted path
//   done          one-cycle pulse the cycle after the last path word
//   error         one-cycle pulse on an invalid id or unreachable end node
module path_planner #(
    parameter int unsigned NODES   = 30,
    parameter int unsigned NW      = 5,
    parameter int unsigned MAX_LEN = 30
) (
    input  logic          clk_3125KHz,
    input  logic          reset,
    input  logic          plan_start,
    input  logic [NW-1:0] start_node,
    input  logic [NW-1:0] end_node,
    output logic          busy,
    output logic          path_input,
    output logic [NW-1:0] path_planned,
    output logic [NW-1:0] path_len,
    output logic          done,
    output logic          error
);

    localparam int unsigned QW  = $clog2(NODES + 1);
    localparam int unsigned SPW = $clog2(MAX_LEN + 1);
    localparam int unsigned VW  = 1 << NW;

    localparam logic [NW-1:0] NONE    = '1;
    localparam logic [NW-1:0] LAST_ID = NW'(NODES - 1);

    // Neighbour slots, slot 0 first; ascending ids, unused slots hold NONE.
    typedef logic [0:3][NW-1:0] adj_row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_INIT,
        S_DEQ,
        S_SCAN,
        S_BACKTRACK,
        S_EMIT,
        S_DONE
    } state_t;

    // Fixed arena adjacency ROM.
    function automatic adj_row_t adj_lookup(input logic [NW-1:0] n);
        adj_row_t row;
        row = {4{NONE}};
        case (n)
            5'd0:  row = {5'd1,  NONE,   NONE,   NONE};
            5'd1:  row = {5'd0,  5'd2,  5'd29, NONE};
            5'd2:  row = {5'd1,  5'd3,  5'd8,  NONE};
            5'd3:  row = {5'd2,  5'd4,  5'd28, NONE};
            5'd4:  row = {5'd3,  5'd5,  5'd6,  NONE};
            5'd5:  row = {5'd4,  NONE,   NONE,   NONE};
            5'd6:  row = {5'd4,  5'd7,  NONE,   NONE};
            5'd7:  row = {5'd6,  5'd8,  NONE,   NONE};
            5'd8:  row = {5'd2,  5'd7,  5'd9,  5'd12};
            5'd9:  row = {5'd8,  5'd10, 5'd11, NONE};
            5'd10: row = {5'd9,  NONE,   NONE,   NONE};
            5'd11: row = {5'd9,  NONE,   NONE,   NONE};
            5'd12: row = {5'd8,  5'd13, 5'd19, NONE};
            5'd13: row = {5'd12, 5'd14, NONE,   NONE};
            5'd14: row = {5'd13, 5'd15, 5'd16, NONE};
            5'd15: row = {5'd14, NONE,   NONE,   NONE};
            5'd16: row = {5'd14, 5'd17, 5'd18, NONE};
            5'd17: row = {5'd16, NONE,   NONE,   NONE};
            5'd18: row = {5'd16, 5'd19, NONE,   NONE};
            5'd19: row = {5'd12, 5'd18, 5'd20, NONE};
            5'd20: row = {5'd19, 5'd21, 5'd24, 5'd29};
            5'd21: row = {5'd20, 5'd22, 5'd23, NONE};
            5'd22: row = {5'd21, NONE,   NONE,   NONE};
            5'd23: row = {5'd21, NONE,   NONE,   NONE};
            5'd24: row = {5'd20, 5'd25, NONE,   NONE};
            5'd25: row = {5'd24, 5'd26, NONE,   NONE};
            5'd26: row = {5'd25, 5'd27, 5'd28, NONE};
            5'd27: row = {5'd26, NONE,   NONE,   NONE};
            5'd28: row = {5'd3,  5'd26, 5'd29, NONE};
            5'd29: row = {5'd1,  5'd20, 5'd28, NONE};
            default: row = {4{NONE}};
        endcase
        return row;
    endfunction

    state_t          state;
    state_t          next_state;

    logic [NW-1:0]   start_r;
    logic [NW-1:0]   end_r;
    logic [NW-1:0]   cur;
    logic [NW-1:0]   bt;
    logic [1:0]      slot;
    logic [VW-1:0]   visited;
    logic [QW-1:0]   q_head;
    logic [QW-1:0]   q_tail;
    logic [SPW-1:0]  sp;

    logic [NW-1:0]   parent [NODES];
    logic [NW-1:0]   q_mem  [NODES];
    logic [NW-1:0]   stack  [MAX_LEN];

    adj_row_t        adj_row_c;
    logic [NW-1:0]   nb_c;
    logic            ids_bad_c;
    logic            q_empty_c;
    logic            nb_new_c;
    logic            nb_hit_c;

    logic            busy_d;
    logic            path_input_d;
    logic [NW-1:0]   path_planned_d;
    logic            done_d;
    logic            error_d;

    assign adj_row_c = adj_lookup(cur);
    assign nb_c      = adj_row_c[slot];
    assign ids_bad_c = (start_r > LAST_ID) || (end_r > LAST_ID);
    assign q_empty_c = (q_head == q_tail);
    assign nb_new_c  = (nb_c != NONE) && !visited[nb_c];
    assign nb_hit_c  = nb_new_c && (nb_c == end_r);

    // State register.
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (plan_start) next_state = S_CHECK;
            S_CHECK: begin
                if (ids_bad_c)             next_state = S_IDLE;
                else if (start_r == end_r) next_state = S_EMIT;
                else                       next_state = S_INIT;
            end
            S_INIT:      next_state = S_DEQ;
            S_DEQ:       next_state = q_empty_c ? S_IDLE : S_SCAN;
            // Lists are ascending with NONE at the tail, so NONE ends the scan.
            S_SCAN: begin
                if (nb_hit_c)                           next_state = S_BACKTRACK;
                else if ((nb_c == NONE) || (slot == 2'd3)) next_state = S_DEQ;
            end
            S_BACKTRACK: if (bt == start_r) next_state = S_EMIT;
            S_EMIT:      if (sp == SPW'(1)) next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Output decode; values land in the output registers one cycle later.
    always_comb begin
        busy_d         = (next_state != S_IDLE);
        path_input_d   = (state == S_EMIT);
        path_planned_d = '0;
        done_d         = (state == S_DONE);
        error_d        = ((state == S_CHECK) && ids_bad_c) ||
                         ((state == S_DEQ) && q_empty_c);
        if (state == S_EMIT) begin
            path_planned_d = stack[sp - SPW'(1)];
        end
    end

    // Output registers and search control.
    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            busy         <= 1'b0;
            path_input   <= 1'b0;
            path_planned <= '0;
            path_len     <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            start_r      <= '0;
            end_r        <= '0;
            cur          <= '0;
            bt           <= '0;
            slot         <= '0;
            visited      <= '0;
            q_head       <= '0;
            q_tail       <= '0;
            sp           <= '0;
        end else begin
            busy         <= busy_d;
            path_input   <= path_input_d;
            path_planned <= path_planned_d;
            done         <= done_d;
            error        <= error_d;
            case (state)
                S_IDLE: begin
                    if (plan_start) begin
                        start_r <= start_node;
                        end_r   <= end_node;
                    end
                end
                S_CHECK: begin
                    if (!ids_bad_c && (start_r == end_r)) begin
                        sp       <= SPW'(1);
                        path_len <= NW'(1);
                    end
                end
                S_INIT: begin
                    visited <= VW'(1) << start_r;
                    q_head  <= '0;
                    q_tail  <= QW'(1);
                end
                S_DEQ: begin
                    if (!q_empty_c) begin
                        cur    <= q_mem[q_head];
                        q_head <= q_head + QW'(1);
                        slot   <= '0;
                    end
                end
                S_SCAN: begin
                    slot <= slot + 2'd1;
                    if (nb_new_c) begin
                        visited[nb_c] <= 1'b1;
                        q_tail        <= q_tail + QW'(1);
                    end
                    if (nb_hit_c) begin
                        bt <= end_r;
                        sp <= '0;
                    end
                end
                S_BACKTRACK: begin
                    sp <= sp + SPW'(1);
                    if (bt == start_r) begin
                        path_len <= NW'(sp + SPW'(1));
                    end else begin
                        bt <= parent[bt];
                    end
                end
                S_EMIT:  sp <= sp - SPW'(1);
                default: ;
            endcase
        end
    end

    // Parent table, BFS queue and path stack storage.
    always_ff @(posedge clk_3125KHz) begin
        case (state)
            S_CHECK: stack[0] <= start_r;
            S_INIT: begin
                parent   <= '{default: '0};
                q_mem[0] <= start_r;
            end
            S_SCAN: begin
                if (nb_new_c) begin
                    parent[nb_c]  <= cur;
                    q_mem[q_tail] <= nb_c;
                end
            end
            S_BACKTRACK: stack[sp] <= bt;
            default: ;
        endcase
    end

endmodule

// File: doc/path_planner.md
Name: path_planner

Overview:
- Computes the shortest node path between a start node and an end node on the fixed 30-node arena graph, using a breadth-first search.
- Streams the result, start node first and end node last, into the downstream path-mapping stage. That stage loads its planned-path array from this stream.
- Sits between the CPU/command decoder, which supplies the start/end pair, and the path-mapping/turn logic.

Parameters:
- NODES, 30, number of arena nodes; valid ids are 0..NODES-1.
- NW, 5, node id width.
- MAX_LEN, 30, maximum emitted path length in nodes.

Ports:
- clk_3125KHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- plan_start  input  1  one-cycle request; samples start_node and end_node.
- start_node  input  5  source node id.
- end_node  input  5  destination node id.
- busy  output  1  high from the cycle after an accepted plan_start until done or error is asserted.
- path_input  output  1  path stream valid strobe.
- path_planned  output  5  path node id; meaningful only while path_input=1.
- path_len  output  5  number of nodes in the path; valid from the first path_input cycle until the next accepted plan_start.
- done  output  1  one-cycle pulse, the cycle after the last path_input.
- error  output  1  one-cycle pulse on an invalid id or an unreachable end node.

Behaviour:
- Graph: undirected, fixed at synthesis. Edges:
  - 0-1, 1-2, 1-29, 2-3, 2-8, 3-4, 3-28, 4-5, 4-6, 6-7, 7-8, 8-9, 8-12
  - 9-10, 9-11, 12-13, 12-19, 13-14, 14-15, 14-16, 16-17, 16-18, 18-19
  - 19-20, 20-21, 20-24, 20-29, 21-22, 21-23, 24-25, 25-26, 26-27, 26-28, 28-29
  - Each node's neighbour list is stored in ascending node-id order, maximum 4 neighbours; unused slots hold 5'd31.
- Reset values: busy=0, path_input=0, path_planned=0, path_len=0, done=0, error=0, FSM=IDLE. Reset takes priority in any state; an in-flight stream is abandoned with no done or error pulse.
- IDLE:
  - plan_start=1 latches start_node and end_node, then goes to CHECK.
  - plan_start while not IDLE is ignored.
- CHECK (1 cycle):
  - Either id >= NODES: error pulse, back to IDLE, no stream.
  - start==end: go to EMIT with a 1-node path.
  - Otherwise go to INIT.
- INIT:
  - Clear the visited bits and parent table (parallel clear, or one node per cycle, at most NODES cycles).
  - Mark start visited, enqueue start, go to SEARCH.
- SEARCH:
  - Queue is a NODES-deep FIFO of node ids; it never overflows because each node is enqueued at most once.
  - Dequeue the head node, then examine its neighbour slots one per cycle in ascending order.
  - Each unvisited valid neighbour is marked visited, gets parent=head, and is enqueued.
  - When end is discovered, go to BACKTRACK immediately.
  - Queue empty without finding end: error pulse, back to IDLE.
- BACKTRACK:
  - From end, follow parent pointers, pushing each node onto a MAX_LEN-deep stack, one node per cycle, until start is pushed.
  - The stack count becomes path_len.
- EMIT:
  - Pop one node per cycle with path_input=1, so path_input is high for exactly path_len consecutive cycles with no gaps.
  - First word is start, last word is end.
- DONE:
  - done=1 for one cycle in the cycle after the last word; busy drops in that same cycle; back to IDLE.
- Tie-breaking: the ascending-neighbour scan combined with FIFO order fixes the path. Equal-length alternatives resolve to the one discovered first, so results are bit-exact and repeatable.
- Latency: plan_start to first path_input is at most 200 cycles for any pair on this graph.

Test Plan:
- Reset, then plan_start with start=0, end=7 -> path_input for 5 cycles carrying 0,1,2,8,7; path_len=5; done pulse on the following cycle; busy low after it.
- start=0, end=27 -> stream 0,1,29,28,26,27; path_len=6.
- Tie case, start=12, end=16 -> stream 12,13,14,16, not 12,19,18,16; path_len=4.
- start=5, end=5 -> single word 5; path_len=1; done on the next cycle.
- Invalid input, end=30 -> error pulse within 2 cycles; no path_input; busy returns low. A second plan_start while busy is ignored: the stream for the first request is unchanged.
- Assert reset during EMIT of the 0->27 stream -> the next cycle has all outputs 0 with no done or error. A fresh request 0->7 afterwards still yields 0,1,2,8,7.
